// File: rtl/reg_wr_arbiter.sv
// Sole owner of the register-file write port: clears the file after reset or on
// request, then round-robin arbitrates ALU (0) and load-unit (1) writebacks.
module reg_wr_arbiter #(
    parameter int unsigned n       = 32,
    parameter int unsigned NREG    = 32,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         init_req,
    input  logic         req0,
    input  logic [4:0]   rw0,
    input  logic [n-1:0] data0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [4:0]   rw1,
    input  logic [n-1:0] data1,
    output logic         gnt1,
    output logic         RegWr,
    output logic [4:0]   Rw,
    output logic [n-1:0] busW,
    output logic         init_busy
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(NREG - 1);

    state_t       state, state_d;
    logic [4:0]   cnt, cnt_d;
    logic         last, last_d;
    logic         regwr_d;
    logic [4:0]   rw_d;
    logic [n-1:0] busw_d;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= INIT;
            cnt   <= '0;
            last  <= 1'b1;
            RegWr <= 1'b0;
            Rw    <= '0;
            busW  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            last  <= last_d;
            RegWr <= regwr_d;
            Rw    <= rw_d;
            busW  <= busw_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        last_d    = last;
        regwr_d   = 1'b0;
        rw_d      = Rw;
        busw_d    = busW;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        init_busy = (state == INIT);

        unique case (state)
            INIT: begin
                if (init_req) begin
                    cnt_d = '0;
                end else begin
                    regwr_d = 1'b1;
                    rw_d    = cnt;
                    busw_d  = '0;
                    if (cnt == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt + 5'd1;
                    end
                end
            end

            RUN: begin
                if (init_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    // last names the most recent winner; the other side wins a tie
                    gnt0 = req0 & (~req1 | last);
                    gnt1 = req1 & (~req0 | ~last);
                    if (gnt0) begin
                        rw_d    = rw0;
                        busw_d  = data0;
                        last_d  = 1'b0;
                        regwr_d = !(ZERO_R0 && (rw0 == 5'd0));
                    end else if (gnt1) begin
                        rw_d    = rw1;
                        busw_d  = data1;
                        last_d  = 1'b1;
                        regwr_d = !(ZERO_R0 && (rw1 == 5'd0));
                    end
                end
            end

            default: state_d = INIT;
        endcase
    end

endmodule
